// File: rtl/spi_txn_arbiter_if.sv
// Register bus between the transaction arbiter and a memory-mapped SPI master.
// Read data is combinational from the slave in the cycle the read strobe is high.
interface spi_txn_arbiter_if;
    logic        m_sel;
    logic        m_w_en;
    logic        m_r_en;
    logic [1:0]  m_offset;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport master (
        output m_sel,
        output m_w_en,
        output m_r_en,
        output m_offset,
        output m_wdata,
        input  m_rdata
    );

    modport slave (
        input  m_sel,
        input  m_w_en,
        input  m_r_en,
        input  m_offset,
        input  m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that runs one full SPI master register sequence per granted
// requester and returns the received byte with a one-cycle acknowledge.
module spi_txn_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_tx,
    input  logic [8*N_REQ-1:0]   req_clkdiv,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     err,
    output logic [7:0]           rx_data,
    spi_txn_arbiter_if.master    bus
);

    localparam int                IDX_W    = $clog2(N_REQ);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0]  ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_TX     = 4'd1,
        S_WR_START  = 4'd2,
        S_POLL_BUSY = 4'd3,
        S_WR_STOP   = 4'd4,
        S_POLL_DONE = 4'd5,
        S_RD_RX     = 4'd6,
        S_CLR_DONE  = 4'd7,
        S_FINISH    = 4'd8,
        S_ABORT     = 4'd9
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_cur;
    logic [IDX_W-1:0]   w_cur_next;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   w_winner;
    logic               w_found;
    logic [7:0]         r_div;
    logic [7:0]         w_div_next;
    logic [7:0]         w_tx_sel;
    logic [15:0]        r_tmo;
    logic [15:0]        w_tmo_next;
    logic               w_busy;
    logic               w_done;
    logic               w_start;

    logic               w_sel, w_w_en, w_r_en;
    logic [1:0]         w_offset;
    logic [31:0]        w_wdata;
    logic [N_REQ-1:0]   w_gnt, w_ack, w_err;
    logic               r_sel, r_w_en, r_r_en;
    logic [1:0]         r_offset;
    logic [31:0]        r_wdata;
    logic [N_REQ-1:0]   r_gnt, r_ack, r_err;
    logic [7:0]         r_rx;

    assign w_busy  = bus.m_rdata[0];
    assign w_done  = bus.m_rdata[1];
    assign w_start = (r_state == S_IDLE) && w_found;

    // Round-robin search beginning just after the last served requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!w_found && req[(int'(r_last) + i) % N_REQ]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'((int'(r_last) + i) % N_REQ);
            end else begin
                w_found  = w_found;
            end
        end
    end

    assign w_tx_sel   = req_tx[{w_winner, 3'b000} +: 8];
    assign w_cur_next = w_start ? w_winner : r_cur;
    assign w_div_next = w_start ? req_clkdiv[{w_winner, 3'b000} +: 8] : r_div;

    // Next-state logic; the poll timer restarts on entry to each poll state.
    always_comb begin
        w_state_next = r_state;
        w_tmo_next   = r_tmo;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_WR_TX;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WR_TX:    w_state_next = S_WR_START;
            S_WR_START: begin
                w_state_next = S_POLL_BUSY;
                w_tmo_next   = 16'd0;
            end
            S_POLL_BUSY: begin
                if (w_busy || w_done) begin
                    w_state_next = S_WR_STOP;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_next = S_ABORT;
                end else begin
                    w_tmo_next   = r_tmo + 16'd1;
                end
            end
            S_WR_STOP: begin
                w_state_next = S_POLL_DONE;
                w_tmo_next   = 16'd0;
            end
            S_POLL_DONE: begin
                if (w_done) begin
                    w_state_next = S_RD_RX;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_next = S_ABORT;
                end else begin
                    w_tmo_next   = r_tmo + 16'd1;
                end
            end
            S_RD_RX:    w_state_next = S_CLR_DONE;
            S_CLR_DONE: w_state_next = S_FINISH;
            S_FINISH:   w_state_next = S_IDLE;
            S_ABORT:    w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        w_w_en   = 1'b0;
        w_r_en   = 1'b0;
        w_offset = 2'd0;
        w_wdata  = 32'd0;
        w_gnt    = {N_REQ{1'b0}};
        w_ack    = {N_REQ{1'b0}};
        w_err    = {N_REQ{1'b0}};
        case (w_state_next)
            S_WR_TX: begin
                w_w_en   = 1'b1;
                w_offset = 2'd1;
                w_wdata  = {24'd0, w_tx_sel};
                w_gnt    = ONE_HOT0 << w_cur_next;
            end
            S_WR_START: begin
                w_w_en   = 1'b1;
                w_offset = 2'd0;
                w_wdata  = {16'd0, w_div_next, 6'd0, 1'b1, 1'b1};
                w_gnt    = ONE_HOT0 << w_cur_next;
            end
            S_POLL_BUSY, S_POLL_DONE: begin
                w_r_en   = 1'b1;
                w_offset = 2'd3;
                w_gnt    = ONE_HOT0 << w_cur_next;
            end
            S_WR_STOP: begin
                // Keep the master enabled but drop start so it cannot auto-restart.
                w_w_en   = 1'b1;
                w_offset = 2'd0;
                w_wdata  = {16'd0, w_div_next, 6'd0, 1'b0, 1'b1};
                w_gnt    = ONE_HOT0 << w_cur_next;
            end
            S_RD_RX: begin
                w_r_en   = 1'b1;
                w_offset = 2'd2;
                w_gnt    = ONE_HOT0 << w_cur_next;
            end
            S_CLR_DONE: begin
                w_w_en   = 1'b1;
                w_offset = 2'd3;
                w_wdata  = 32'h0000_0002;
                w_gnt    = ONE_HOT0 << w_cur_next;
            end
            S_FINISH: begin
                w_ack    = ONE_HOT0 << w_cur_next;
            end
            S_ABORT: begin
                w_w_en   = 1'b1;
                w_offset = 2'd0;
                w_wdata  = 32'd0;
                w_err    = ONE_HOT0 << w_cur_next;
            end
            default: begin
                w_w_en   = 1'b0;
            end
        endcase
        w_sel = w_w_en | w_r_en;
    end

    // Sequencer state, current owner, fairness pointer and poll timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= {IDX_W{1'b0}};
            r_last  <= LAST_RST;
            r_div   <= 8'd0;
            r_tmo   <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_cur   <= w_cur_next;
            r_div   <= w_div_next;
            r_tmo   <= w_tmo_next;
            if (r_state == S_FINISH || r_state == S_ABORT) begin
                r_last <= r_cur;
            end else begin
                r_last <= r_last;
            end
        end
    end

    // Registered bus strobes, handshake pulses and captured RX byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel    <= 1'b0;
            r_w_en   <= 1'b0;
            r_r_en   <= 1'b0;
            r_offset <= 2'd0;
            r_wdata  <= 32'd0;
            r_gnt    <= {N_REQ{1'b0}};
            r_ack    <= {N_REQ{1'b0}};
            r_err    <= {N_REQ{1'b0}};
            r_rx     <= 8'd0;
        end else begin
            r_sel    <= w_sel;
            r_w_en   <= w_w_en;
            r_r_en   <= w_r_en;
            r_offset <= w_offset;
            r_wdata  <= w_wdata;
            r_gnt    <= w_gnt;
            r_ack    <= w_ack;
            r_err    <= w_err;
            if (r_state == S_RD_RX) begin
                r_rx <= bus.m_rdata[7:0];
            end else begin
                r_rx <= r_rx;
            end
        end
    end

    assign bus.m_sel    = r_sel;
    assign bus.m_w_en   = r_w_en;
    assign bus.m_r_en   = r_r_en;
    assign bus.m_offset = r_offset;
    assign bus.m_wdata  = r_wdata;
    assign gnt          = r_gnt;
    assign ack          = r_ack;
    assign err          = r_err;
    assign rx_data      = r_rx;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: an SPI master stub with MISO looped to
// MOSI, and a round-robin reference model of which requester should win next.
module tb_spi_txn_arbiter;
    localparam int N   = 4;
    localparam int TMO = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_tx;
    logic [31:0] req_clkdiv;
    logic [3:0]  gnt, ack, err;
    logic [7:0]  rx_data;

    int checks   = 0;
    int failures = 0;
    int model_last;

    // Stub behaviour: 0 = normal loopback, 1 = busy/done always set, 2 = never done.
    int          slv_mode = 0;
    logic        s_busy = 1'b0, s_done = 1'b0;
    logic [7:0]  s_tx = 8'd0, s_rx = 8'd0;
    int          s_cnt = 0;
    logic [33:0] wq[$];

    // Results of the most recent wait_end call.
    bit          we_to, we_bad, we_gnt_end;
    logic [3:0]  we_ack, we_err, we_gnt;
    int          we_gnt_cyc, we_pre_cyc;

    spi_txn_arbiter_if bus();

    spi_txn_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_tx(req_tx), .req_clkdiv(req_clkdiv),
        .gnt(gnt), .ack(ack), .err(err), .rx_data(rx_data), .bus(bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.m_sel && bus.m_w_en) begin
            case (bus.m_offset)
                2'd0: begin
                    if (bus.m_wdata[0] && bus.m_wdata[1]) begin
                        s_busy <= 1'b1; s_done <= 1'b0;
                        s_cnt  <= 2 * (int'(bus.m_wdata[15:8]) + 1);
                    end else if (!bus.m_wdata[0]) begin
                        s_busy <= 1'b0;
                    end
                end
                2'd1: s_tx <= bus.m_wdata[7:0];
                2'd3: if (bus.m_wdata[1]) s_done <= 1'b0;
                default: ;
            endcase
        end else if (s_busy && slv_mode == 0) begin
            if (s_cnt <= 1) begin
                s_busy <= 1'b0; s_done <= 1'b1; s_rx <= s_tx;
            end else begin
                s_cnt <= s_cnt - 1;
            end
        end
    end

    always_comb begin
        bus.m_rdata = 32'd0;
        if (bus.m_sel && bus.m_r_en) begin
            if (bus.m_offset == 2'd3)
                bus.m_rdata = (slv_mode == 1) ? 32'd3 : {30'd0, s_done, s_busy};
            else if (bus.m_offset == 2'd2)
                bus.m_rdata = {24'd0, (slv_mode == 1) ? s_tx : s_rx};
        end
    end

    always @(negedge clk) begin
        if (bus.m_sel && bus.m_w_en) wq.push_back({bus.m_offset, bus.m_wdata});
    end

    function automatic int rr_pick(input int last, input logic [3:0] m);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic set_data();
        req_tx = $urandom;
        for (int i = 0; i < N; i++) req_clkdiv[8*i +: 8] = 8'($urandom_range(0, 7));
    endtask

    // Observes one transaction up to its ack/err cycle; returns shortly after that edge.
    task automatic wait_end(input int limit);
        we_to = 1'b1; we_bad = 1'b0; we_gnt_end = 1'b0;
        we_ack = 4'd0; we_err = 4'd0; we_gnt = 4'd0; we_gnt_cyc = 0; we_pre_cyc = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if ($countones(gnt) > 1) we_bad = 1'b1;
            if ((bus.m_sel !== (bus.m_w_en | bus.m_r_en)) || (bus.m_w_en && bus.m_r_en)) we_bad = 1'b1;
            if (gnt != 4'd0) begin
                if (we_gnt != 4'd0 && gnt != we_gnt) we_bad = 1'b1;
                we_gnt = gnt; we_gnt_cyc++;
            end else if (we_gnt == 4'd0) begin
                we_pre_cyc++;
            end
            if (ack != 4'd0 || err != 4'd0) begin
                we_ack = ack; we_err = err; we_gnt_end = (gnt != 4'd0); we_to = 1'b0;
                if ($countones(ack | err) != 1) we_bad = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'd0; req_tx = 32'd0; req_clkdiv = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (gnt !== 4'd0) begin failures++; $display("FAIL reset_gnt: got %h want 0", gnt); end
        checks++; if (ack !== 4'd0) begin failures++; $display("FAIL reset_ack: got %h want 0", ack); end
        checks++; if (err !== 4'd0) begin failures++; $display("FAIL reset_err: got %h want 0", err); end
        checks++; if (rx_data !== 8'd0) begin failures++; $display("FAIL reset_rx: got %h want 0", rx_data); end
        checks++; if ({bus.m_sel, bus.m_w_en, bus.m_r_en} !== 3'd0) begin failures++; $display("FAIL reset_strobes: got %b want 000", {bus.m_sel, bus.m_w_en, bus.m_r_en}); end
        checks++; if (bus.m_offset !== 2'd0) begin failures++; $display("FAIL reset_offset: got %h want 0", bus.m_offset); end
        checks++; if (bus.m_wdata !== 32'd0) begin failures++; $display("FAIL reset_wdata: got %h want 0", bus.m_wdata); end
        rst = 1'b0; model_last = N - 1;
    endtask

    task automatic test_single();
        logic [33:0] exp_w[4];
        slv_mode = 0; set_data();
        req_tx[7:0] = 8'hA5; req_clkdiv[7:0] = 8'd2;
        exp_w[0] = {2'd1, 32'h0000_00A5}; exp_w[1] = {2'd0, 32'h0000_0203};
        exp_w[2] = {2'd0, 32'h0000_0201}; exp_w[3] = {2'd3, 32'h0000_0002};
        wq.delete();
        @(negedge clk); req = 4'b0001;
        wait_end(200);
        checks++; if (we_to !== 1'b0) begin failures++; $display("FAIL single_timeout: no ack/err within bound"); end
        checks++; if (we_ack !== 4'b0001) begin failures++; $display("FAIL single_ack: got %h want 1", we_ack); end
        checks++; if (we_gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %h want 1", we_gnt); end
        checks++; if (we_gnt_end !== 1'b0) begin failures++; $display("FAIL single_gnt_drop: gnt still high in ack cycle"); end
        checks++; if (we_bad !== 1'b0) begin failures++; $display("FAIL single_protocol: one-hot/strobe violation seen"); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL single_rx: got %h want a5", rx_data); end
        checks++;
        if (wq.size() != 4) begin
            failures++; $display("FAIL single_wr_count: got %0d want 4", wq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (wq[k] !== exp_w[k]) begin failures++; $display("FAIL single_wr%0d: got %h want %h", k, wq[k], exp_w[k]); end
            end
        end
        req = 4'd0;
        @(negedge clk);
        checks++; if (ack !== 4'd0) begin failures++; $display("FAIL single_ack_pulse: got %h want 0", ack); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL single_rx_hold: got %h want a5", rx_data); end
        model_last = 0;
    endtask

    task automatic test_random();
        int w;
        logic [7:0] tx, dv;
        for (int it = 0; it < 12; it++) begin
            if (req == 4'd0) req = 4'($urandom_range(1, 15));
            slv_mode = 0; set_data(); wq.delete();
            w  = rr_pick(model_last, req);
            tx = req_tx[8*w +: 8]; dv = req_clkdiv[8*w +: 8];
            wait_end(300);
            checks++; if (we_to !== 1'b0 || we_ack !== 4'(1 << w) || we_err !== 4'd0) begin failures++; $display("FAIL rand_ack it%0d: ack %h err %h want ack %h", it, we_ack, we_err, 4'(1 << w)); end
            checks++; if (we_bad !== 1'b0) begin failures++; $display("FAIL rand_protocol it%0d: violation seen", it); end
            checks++; if (rx_data !== tx) begin failures++; $display("FAIL rand_rx it%0d: got %h want %h", it, rx_data, tx); end
            checks++;
            if (wq.size() != 4) begin failures++; $display("FAIL rand_wr_count it%0d: got %0d want 4", it, wq.size()); end
            else if (wq[0] !== {2'd1, 24'd0, tx} || wq[1] !== {2'd0, 16'd0, dv, 8'h03} ||
                     wq[2] !== {2'd0, 16'd0, dv, 8'h01} || wq[3] !== {2'd3, 32'd2}) begin
                failures++; $display("FAIL rand_wr_seq it%0d: got %h %h %h %h", it, wq[0], wq[1], wq[2], wq[3]);
            end
            req[w] = 1'b0; model_last = w;
        end
        req = 4'd0;
    endtask

    task automatic test_round_robin();
        int w;
        rst = 1'b1; req = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0; model_last = N - 1;
        slv_mode = 1; set_data(); req = 4'hF;
        for (int t = 0; t < 5; t++) begin
            w = rr_pick(model_last, 4'hF);
            wait_end(100);
            checks++; if (we_to !== 1'b0 || we_ack !== 4'(1 << w)) begin failures++; $display("FAIL rr_order t%0d: ack %h want %h", t, we_ack, 4'(1 << w)); end
            checks++; if (we_gnt !== 4'(1 << w) || we_bad !== 1'b0) begin failures++; $display("FAIL rr_gnt t%0d: gnt %h want %h bad %0d", t, we_gnt, 4'(1 << w), we_bad); end
            // Minimum latency: seven granted cycles, ack in the eighth.
            checks++; if (we_gnt_cyc != 7) begin failures++; $display("FAIL rr_latency t%0d: gnt cycles %0d want 7", t, we_gnt_cyc); end
            checks++; if (rx_data !== req_tx[8*w +: 8]) begin failures++; $display("FAIL rr_rx t%0d: got %h want %h", t, rx_data, req_tx[8*w +: 8]); end
            if (t > 0) begin
                checks++; if (we_pre_cyc != 1) begin failures++; $display("FAIL rr_gap t%0d: idle cycles %0d want 1", t, we_pre_cyc); end
            end
            model_last = w;
        end
        req = 4'd0;
    endtask

    task automatic test_drop();
        int w;
        bit seen;
        slv_mode = 0; set_data();
        req = 4'b0100; w = rr_pick(model_last, req); seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (gnt != 4'd0) seen = 1'b1;
        end
        checks++; if (gnt !== 4'(1 << w)) begin failures++; $display("FAIL drop_gnt: got %h want %h", gnt, 4'(1 << w)); end
        req = 4'b0010;
        wait_end(300);
        checks++; if (we_to !== 1'b0 || we_ack !== 4'(1 << w)) begin failures++; $display("FAIL drop_ack: got %h want %h", we_ack, 4'(1 << w)); end
        checks++; if (we_bad !== 1'b0) begin failures++; $display("FAIL drop_protocol: gnt changed mid-transaction"); end
        checks++; if (rx_data !== req_tx[8*w +: 8]) begin failures++; $display("FAIL drop_rx: got %h want %h", rx_data, req_tx[8*w +: 8]); end
        model_last = w; w = rr_pick(model_last, req);
        wait_end(300);
        checks++; if (we_to !== 1'b0 || we_ack !== 4'(1 << w)) begin failures++; $display("FAIL drop_next_ack: got %h want %h", we_ack, 4'(1 << w)); end
        req = 4'd0; model_last = w;
    endtask

    task automatic test_timeout();
        int w;
        logic [7:0] prev_rx, dv;
        slv_mode = 2; prev_rx = rx_data; set_data(); wq.delete();
        req = 4'b1000; w = rr_pick(model_last, req); dv = req_clkdiv[8*w +: 8];
        wait_end(300);
        checks++; if (we_to !== 1'b0 || we_err !== 4'(1 << w) || we_ack !== 4'd0) begin failures++; $display("FAIL tmo_err: err %h ack %h want err %h", we_err, we_ack, 4'(1 << w)); end
        checks++; if (we_gnt_cyc != 4 + TMO) begin failures++; $display("FAIL tmo_cycles: gnt cycles %0d want %0d", we_gnt_cyc, 4 + TMO); end
        checks++; if (we_gnt_end !== 1'b0) begin failures++; $display("FAIL tmo_gnt_drop: gnt high in err cycle"); end
        checks++; if (rx_data !== prev_rx) begin failures++; $display("FAIL tmo_rx: got %h want %h", rx_data, prev_rx); end
        checks++;
        if (wq.size() != 4) begin failures++; $display("FAIL tmo_wr_count: got %0d want 4", wq.size()); end
        else if (wq[2] !== {2'd0, 16'd0, dv, 8'h01} || wq[3] !== 34'd0) begin
            failures++; $display("FAIL tmo_wr_seq: got %h %h want stop then ctrl=0", wq[2], wq[3]);
        end
        req = 4'd0; model_last = w;
        @(negedge clk);
        checks++; if (err !== 4'd0) begin failures++; $display("FAIL tmo_err_pulse: got %h want 0", err); end
        slv_mode = 0; req = 4'b1001;
        w = rr_pick(model_last, req);
        wait_end(300);
        checks++; if (we_to !== 1'b0 || we_ack !== 4'(1 << w)) begin failures++; $display("FAIL tmo_recover: ack %h want %h", we_ack, 4'(1 << w)); end
        req[w] = 1'b0; model_last = w; w = rr_pick(model_last, req);
        wait_end(300);
        checks++; if (we_to !== 1'b0 || we_ack !== 4'(1 << w)) begin failures++; $display("FAIL tmo_recover2: ack %h want %h", we_ack, 4'(1 << w)); end
        req = 4'd0; model_last = w;
    endtask

    task automatic test_reset_mid();
        int w;
        bit seen, ack_seen;
        slv_mode = 2; set_data(); req = 4'b0100; seen = 1'b0; ack_seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (gnt != 4'd0) seen = 1'b1;
        end
        repeat (8) @(negedge clk);
        rst = 1'b1; req = 4'b1010;
        @(negedge clk);
        checks++; if (gnt !== 4'd0 || ack !== 4'd0 || err !== 4'd0) begin failures++; $display("FAIL rstmid_hs: gnt %h ack %h err %h want 0", gnt, ack, err); end
        checks++; if ({bus.m_sel, bus.m_w_en, bus.m_r_en} !== 3'd0 || bus.m_offset !== 2'd0 || bus.m_wdata !== 32'd0) begin failures++; $display("FAIL rstmid_bus: strobes %b off %h wdata %h want 0", {bus.m_sel, bus.m_w_en, bus.m_r_en}, bus.m_offset, bus.m_wdata); end
        checks++; if (rx_data !== 8'd0) begin failures++; $display("FAIL rstmid_rx: got %h want 0", rx_data); end
        repeat (2) begin
            @(negedge clk);
            if (ack != 4'd0 || err != 4'd0) ack_seen = 1'b1;
        end
        checks++; if (ack_seen !== 1'b0) begin failures++; $display("FAIL rstmid_noack: ack/err seen during reset"); end
        rst = 1'b0; slv_mode = 0; model_last = N - 1;
        w = rr_pick(model_last, req);
        wait_end(300);
        checks++; if (we_to !== 1'b0 || we_ack !== 4'(1 << w)) begin failures++; $display("FAIL rstmid_first: ack %h want %h", we_ack, 4'(1 << w)); end
        req[w] = 1'b0; model_last = w; w = rr_pick(model_last, req);
        wait_end(300);
        checks++; if (we_to !== 1'b0 || we_ack !== 4'(1 << w)) begin failures++; $display("FAIL rstmid_second: ack %h want %h", we_ack, 4'(1 << w)); end
        req = 4'd0; model_last = w;
    endtask

    initial begin
        test_reset();
        test_single();
        test_random();
        test_round_robin();
        test_drop();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
